// File: rtl/sccb_apb_arbiter.sv
// sccb_apb_arbiter
// Shares the single downstream APB completer of the SCCB APB bridge (host-side
// transaction injector) among NUM_REQ upstream APB requesters. One transaction
// is granted at a time in round-robin order. The transaction is replayed
// downstream and its response is returned to the winner. Every downstream
// access phase is bounded by TIMEOUT cycles, and is also aborted when the link
// drops.
//
// Ports:
//   clk, rst                  clock (also the downstream pclk), sync active-high reset
//   link_up                   bridge tx link-layer up; arbitration is blocked while low
//   req_psel/penable/pwrite   per-requester APB control, one bit per port
//   req_paddr/pwdata/pstrb    packed per-requester address/data/strobe, port i at [i*W +: W]
//   req_pready                per-requester ready, pulses only for the granted port
//   req_prdata/req_pslverr    shared response, zero unless a req_pready bit is set
//   m_*                       downstream APB requester port
//   grant_id                  current/last granted port
//   busy                      FSM not in IDLE
//   timeout_err               sticky timeout-abort flag, cleared only by rst
module sccb_apb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023,
  localparam int GW = $clog2(NUM_REQ),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          link_up,
  input  logic [NUM_REQ-1:0]            req_psel,
  input  logic [NUM_REQ-1:0]            req_penable,
  input  logic [NUM_REQ-1:0]            req_pwrite,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_paddr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_pwdata,
  input  logic [NUM_REQ*SW-1:0]         req_pstrb,
  output logic [NUM_REQ-1:0]            req_pready,
  output logic [DATA_WIDTH-1:0]         req_prdata,
  output logic                          req_pslverr,
  output logic                          m_psel,
  output logic                          m_penable,
  output logic                          m_pwrite,
  output logic [ADDR_WIDTH-1:0]         m_paddr,
  output logic [DATA_WIDTH-1:0]         m_pwdata,
  output logic [SW-1:0]                 m_pstrb,
  input  logic                          m_pready,
  input  logic                          m_pslverr,
  input  logic [DATA_WIDTH-1:0]         m_prdata,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] TMO_C = 16'(TIMEOUT);

  state_t                  state_r, state_n;
  logic [GW-1:0]           last_grant_r, last_grant_n;
  logic [GW-1:0]           grant_id_r, grant_id_n;
  logic                    m_psel_r, m_psel_n;
  logic                    m_penable_r, m_penable_n;
  logic                    m_pwrite_r, m_pwrite_n;
  logic [ADDR_WIDTH-1:0]   m_paddr_r, m_paddr_n;
  logic [DATA_WIDTH-1:0]   m_pwdata_r, m_pwdata_n;
  logic [SW-1:0]           m_pstrb_r, m_pstrb_n;
  logic [15:0]             cnt_r, cnt_n;
  logic [DATA_WIDTH-1:0]   resp_data_r, resp_data_n;
  logic                    resp_err_r, resp_err_n;
  logic [NUM_REQ-1:0]      req_pready_r, req_pready_n;
  logic [DATA_WIDTH-1:0]   req_prdata_r, req_prdata_n;
  logic                    req_pslverr_r, req_pslverr_n;
  logic                    busy_r, busy_n;
  logic                    timeout_err_r, timeout_err_n;

  logic                    win_found_s;
  logic [GW-1:0]           win_idx_s;
  logic                    gnt_sel_s;
  logic                    gnt_en_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;

  // Round-robin search: first requesting port after last_grant, wrapping.
  always_comb begin
    logic [GW-1:0] cand;
    cand        = '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(last_grant_r) + i) % NUM_REQ);
      if (!win_found_s && req_psel[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  assign gnt_sel_s = req_psel[grant_id_r];
  assign gnt_en_s  = req_penable[grant_id_r];
  // Read data is meaningless on a write; never pass it upstream.
  assign rd_data_s = m_pwrite_r ? '0 : m_prdata;

  // Next-state and next-output logic for every registered signal.
  always_comb begin
    state_n       = state_r;
    last_grant_n  = last_grant_r;
    grant_id_n    = grant_id_r;
    m_psel_n      = m_psel_r;
    m_penable_n   = m_penable_r;
    m_pwrite_n    = m_pwrite_r;
    m_paddr_n     = m_paddr_r;
    m_pwdata_n    = m_pwdata_r;
    m_pstrb_n     = m_pstrb_r;
    cnt_n         = cnt_r;
    resp_data_n   = resp_data_r;
    resp_err_n    = resp_err_r;
    timeout_err_n = timeout_err_r;
    // Response outputs are single-cycle pulses, zero otherwise.
    req_pready_n  = '0;
    req_prdata_n  = '0;
    req_pslverr_n = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (link_up && win_found_s) begin
          m_pwrite_n   = req_pwrite[win_idx_s];
          m_paddr_n    = req_paddr[win_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
          m_pwdata_n   = req_pwdata[win_idx_s*DATA_WIDTH +: DATA_WIDTH];
          m_pstrb_n    = req_pstrb[win_idx_s*SW +: SW];
          grant_id_n   = win_idx_s;
          last_grant_n = win_idx_s;
          m_psel_n     = 1'b1;
          state_n      = ST_SETUP;
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (!link_up) begin
          m_psel_n    = 1'b0;
          m_penable_n = 1'b0;
          resp_data_n = '0;
          resp_err_n  = 1'b1;
          state_n     = ST_RESP;
        end else begin
          m_penable_n = 1'b1;
          cnt_n       = 16'd0;
          state_n     = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (m_pready) begin
          resp_data_n = rd_data_s;
          resp_err_n  = m_pslverr;
          m_psel_n    = 1'b0;
          m_penable_n = 1'b0;
          state_n     = ST_RESP;
          // Requester already in its access phase: answer in the same cycle
          // RESP is entered, saving a cycle on the common path.
          if (gnt_sel_s && gnt_en_s) begin
            req_pready_n[grant_id_r] = 1'b1;
            req_prdata_n             = rd_data_s;
            req_pslverr_n            = m_pslverr;
          end else begin
            req_pready_n = '0;
          end
        end else if (!link_up || (cnt_r == TMO_C)) begin
          m_psel_n      = 1'b0;
          m_penable_n   = 1'b0;
          resp_data_n   = '0;
          resp_err_n    = 1'b1;
          timeout_err_n = timeout_err_r | (cnt_r == TMO_C);
          state_n       = ST_RESP;
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end

      ST_RESP: begin
        if (|req_pready_r) begin
          // Response pulse is on the bus this cycle; it completes now.
          state_n = ST_IDLE;
        end else if (gnt_sel_s && gnt_en_s) begin
          req_pready_n[grant_id_r] = 1'b1;
          req_prdata_n             = resp_data_r;
          req_pslverr_n            = resp_err_r;
          state_n                  = ST_RESP;
        end else if (!gnt_sel_s) begin
          // Requester abandoned the transfer; drop the response.
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RESP;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      last_grant_r  <= GW'(NUM_REQ - 1);
      grant_id_r    <= '0;
      m_psel_r      <= 1'b0;
      m_penable_r   <= 1'b0;
      m_pwrite_r    <= 1'b0;
      m_paddr_r     <= '0;
      m_pwdata_r    <= '0;
      m_pstrb_r     <= '0;
      cnt_r         <= 16'd0;
      resp_data_r   <= '0;
      resp_err_r    <= 1'b0;
      req_pready_r  <= '0;
      req_prdata_r  <= '0;
      req_pslverr_r <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      last_grant_r  <= last_grant_n;
      grant_id_r    <= grant_id_n;
      m_psel_r      <= m_psel_n;
      m_penable_r   <= m_penable_n;
      m_pwrite_r    <= m_pwrite_n;
      m_paddr_r     <= m_paddr_n;
      m_pwdata_r    <= m_pwdata_n;
      m_pstrb_r     <= m_pstrb_n;
      cnt_r         <= cnt_n;
      resp_data_r   <= resp_data_n;
      resp_err_r    <= resp_err_n;
      req_pready_r  <= req_pready_n;
      req_prdata_r  <= req_prdata_n;
      req_pslverr_r <= req_pslverr_n;
      busy_r        <= busy_n;
      timeout_err_r <= timeout_err_n;
    end
  end

  assign req_pready  = req_pready_r;
  assign req_prdata  = req_prdata_r;
  assign req_pslverr = req_pslverr_r;
  assign m_psel      = m_psel_r;
  assign m_penable   = m_penable_r;
  assign m_pwrite    = m_pwrite_r;
  assign m_paddr     = m_paddr_r;
  assign m_pwdata    = m_pwdata_r;
  assign m_pstrb     = m_pstrb_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_sccb_apb_arbiter.sv
// Testbench for sccb_apb_arbiter: directed steps, a scoreboard of expected
// upstream responses and expected downstream transactions, and a simple
// downstream completer model with a memory, wait states and a "dead" mode.
module tb_sccb_apb_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              link_up;
  logic [NR-1:0]     req_psel;
  logic [NR-1:0]     req_penable;
  logic [NR-1:0]     req_pwrite;
  logic [NR*AW-1:0]  req_paddr;
  logic [NR*DW-1:0]  req_pwdata;
  logic [NR*SW-1:0]  req_pstrb;
  logic [NR-1:0]     req_pready;
  logic [DW-1:0]     req_prdata;
  logic              req_pslverr;
  logic              m_psel;
  logic              m_penable;
  logic              m_pwrite;
  logic [AW-1:0]     m_paddr;
  logic [DW-1:0]     m_pwdata;
  logic [SW-1:0]     m_pstrb;
  logic              m_pready;
  logic              m_pslverr;
  logic [DW-1:0]     m_prdata;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  sccb_apb_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .link_up(link_up),
    .req_psel(req_psel), .req_penable(req_penable), .req_pwrite(req_pwrite),
    .req_paddr(req_paddr), .req_pwdata(req_pwdata), .req_pstrb(req_pstrb),
    .req_pready(req_pready), .req_prdata(req_prdata), .req_pslverr(req_pslverr),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } job_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  job_t        jobs [NR][$];
  job_t        dn_q [$];
  exp_t        exp_q [$];
  logic [31:0] mem [logic [31:0]];

  int checks   = 0;
  int failures = 0;

  bit dead        = 1'b0;
  int wait_states = 0;
  int wcnt        = 0;
  bit m_psel_prev = 1'b0;
  int pen_cycles  = 0;
  int fall_cyc    = 0;
  int pready_cyc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic queue_job(input int p, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb,
                           input logic [31:0] exp_rdata, input logic exp_err);
    job_t j;
    exp_t e;
    j.wr = wr; j.addr = addr; j.data = data; j.strb = strb;
    e.port = p; e.rdata = exp_rdata; e.err = exp_err;
    jobs[p].push_back(j);
    dn_q.push_back(j);
    exp_q.push_back(e);
  endtask

  task automatic load(input int p);
    job_t j;
    j = jobs[p].pop_front();
    req_psel[p]            = 1'b1;
    req_penable[p]         = 1'b0;
    req_pwrite[p]          = j.wr;
    req_paddr[p*AW +: AW]  = j.addr;
    req_pwdata[p*DW +: DW] = j.data;
    req_pstrb[p*SW +: SW]  = j.strb;
  endtask

  task automatic resp_check(input int p);
    exp_t e;
    chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("resp_port", 64'(p), 64'(e.port));
      chk("resp_grant_id", 64'(grant_id), 64'(e.port));
      chk("resp_prdata", 64'(req_prdata), 64'(e.rdata));
      chk("resp_pslverr", 64'(req_pslverr), 64'(e.err));
    end
  endtask

  // One negedge worth of completer model and requester behaviour.
  task automatic step();
    job_t d;
    logic [NR-1:0] psel_snap;
    psel_snap = req_psel;
    if (m_psel && !m_psel_prev) begin
      chk("dn_nonempty", 64'(dn_q.size() != 0), 64'd1);
      if (dn_q.size() != 0) begin
        d = dn_q.pop_front();
        chk("dn_pwrite", 64'(m_pwrite), 64'(d.wr));
        chk("dn_paddr", 64'(m_paddr), 64'(d.addr));
        chk("dn_pwdata", 64'(m_pwdata), 64'(d.data));
        chk("dn_pstrb", 64'(m_pstrb), 64'(d.strb));
      end
      pen_cycles = 0;
    end
    if (!m_psel && m_psel_prev) fall_cyc = cyc_cnt;
    if (m_psel && m_penable) pen_cycles++;
    m_psel_prev = m_psel;

    if (m_psel && m_penable && !dead && (wcnt >= wait_states)) begin
      m_pready = 1'b1;
      if (m_pwrite) begin
        mem[m_paddr] = m_pwdata;
        m_prdata     = 32'h5a5a_5a5a;
      end else begin
        m_prdata = mem.exists(m_paddr) ? mem[m_paddr] : 32'h0;
      end
    end else begin
      m_pready = 1'b0;
      if (m_psel && m_penable) wcnt++;
      else wcnt = 0;
    end

    chk("stray_pready", 64'(req_pready & ~psel_snap), 64'd0);
    if (req_pready == '0) begin
      chk("idle_prdata", 64'(req_prdata), 64'd0);
      chk("idle_pslverr", 64'(req_pslverr), 64'd0);
    end
    for (int p = 0; p < NR; p++) begin
      if (psel_snap[p]) begin
        if (req_pready[p]) begin
          pready_cyc = cyc_cnt;
          resp_check(p);
          if (jobs[p].size() > 0) load(p);
          else begin req_psel[p] = 1'b0; req_penable[p] = 1'b0; end
        end else if (!req_penable[p]) begin
          req_penable[p] = 1'b1;
        end
      end
    end
  endtask

  function automatic bit pending();
    bit any;
    any = (req_psel != '0);
    for (int p = 0; p < NR; p++) if (jobs[p].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic run(input int budget);
    int n;
    n = 0;
    for (int p = 0; p < NR; p++)
      if (!req_psel[p] && jobs[p].size() > 0) load(p);
    while (pending() && n < budget) begin
      @(negedge clk);
      n++;
      step();
    end
    chk("run_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_psel"}, 64'(m_psel), 64'd0);
    chk({tag, "_m_penable"}, 64'(m_penable), 64'd0);
    chk({tag, "_m_pwrite"}, 64'(m_pwrite), 64'd0);
    chk({tag, "_m_paddr"}, 64'(m_paddr), 64'd0);
    chk({tag, "_m_pwdata"}, 64'(m_pwdata), 64'd0);
    chk({tag, "_m_pstrb"}, 64'(m_pstrb), 64'd0);
    chk({tag, "_req_pready"}, 64'(req_pready), 64'd0);
    chk({tag, "_req_prdata"}, 64'(req_prdata), 64'd0);
    chk({tag, "_req_pslverr"}, 64'(req_pslverr), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_psel = '0; req_penable = '0; m_pready = 1'b0;
    @(negedge clk);
    rst = 1'b0; m_psel_prev = 1'b0; wcnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; link_up = 1'b1;
    req_psel = '0; req_penable = '0; req_pwrite = '0;
    req_paddr = '0; req_pwdata = '0; req_pstrb = '0;
    m_pready = 1'b0; m_pslverr = 1'b0; m_prdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);

    // Single write on port 0, best-case timing checked cycle by cycle.
    exp_q.push_back('{port: 0, rdata: 32'h0, err: 1'b0});
    req_psel[0] = 1'b1; req_pwrite[0] = 1'b1;
    req_paddr[0 +: AW] = 32'hbaad_c0de; req_pwdata[0 +: DW] = 32'hdead_beef;
    req_pstrb[0 +: SW] = 4'hf;
    @(negedge clk);                           // cycle 1
    chk("t1_c1_m_psel", 64'(m_psel), 64'd1);
    chk("t1_c1_m_penable", 64'(m_penable), 64'd0);
    chk("t1_m_pwrite", 64'(m_pwrite), 64'd1);
    chk("t1_m_paddr", 64'(m_paddr), 64'hbaad_c0de);
    chk("t1_m_pwdata", 64'(m_pwdata), 64'hdead_beef);
    chk("t1_m_pstrb", 64'(m_pstrb), 64'hf);
    chk("t1_busy", 64'(busy), 64'd1);
    req_penable[0] = 1'b1;
    @(negedge clk);                           // cycle 2
    chk("t1_c2_m_penable", 64'(m_penable), 64'd1);
    chk("t1_c2_req_pready", 64'(req_pready), 64'd0);
    m_pready = 1'b1; m_prdata = 32'h1234_5678;
    @(negedge clk);                           // cycle 3
    chk("t1_c3_req_pready", 64'(req_pready), 64'b0001);
    chk("t1_c3_m_psel", 64'(m_psel), 64'd0);
    resp_check(0);
    req_psel[0] = 1'b0; req_penable[0] = 1'b0; m_pready = 1'b0;
    @(negedge clk);                           // cycle 4
    chk("t1_c4_req_pready", 64'(req_pready), 64'd0);
    chk("t1_c4_busy", 64'(busy), 64'd0);

    // Write then read on port 2 with two completer wait states.
    wait_states = 2;
    queue_job(2, 1'b1, 32'hcafe_babe, 32'hfeed_face, 4'hf, 32'h0, 1'b0);
    queue_job(2, 1'b0, 32'hcafe_babe, 32'h0, 4'h0, 32'hfeed_face, 1'b0);
    run(60);
    wait_states = 0;

    // All four ports at once, two rounds: writes, then read-back.
    apply_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NR; p++)
        queue_job(p, (k == 0), 32'h1000_0000 + 32'(p * 16),
                  (k == 0) ? (32'ha000_0000 | 32'(p << 8)) : 32'h0,
                  (k == 0) ? 4'hf : 4'h0,
                  (k == 0) ? 32'h0 : (32'ha000_0000 | 32'(p << 8)), 1'b0);
    run(200);

    // Dead completer: timeout abort after TMO+1 access cycles.
    dead = 1'b1;
    queue_job(0, 1'b0, 32'h3000_0000, 32'h0, 4'h0, 32'h0, 1'b1);
    run(100);
    chk("to_access_cycles", 64'(pen_cycles), 64'(TMO + 1));
    chk("to_pready_latency", 64'(pready_cyc - fall_cyc), 64'd1);
    chk("to_timeout_err", 64'(timeout_err), 64'd1);
    dead = 1'b0;
    queue_job(0, 1'b0, 32'hcafe_babe, 32'h0, 4'h0, 32'hfeed_face, 1'b0);
    run(60);
    chk("to_sticky", 64'(timeout_err), 64'd1);

    // Link down blocks arbitration; a drop mid-access aborts without timeout_err.
    apply_reset();
    link_up = 1'b0; dead = 1'b1;
    queue_job(1, 1'b0, 32'h2000_0010, 32'h0, 4'h0, 32'h0, 1'b1);
    load(1);
    repeat (5) begin @(negedge clk); step(); end
    chk("lnk_no_m_psel", 64'(m_psel), 64'd0);
    chk("lnk_not_busy", 64'(busy), 64'd0);
    link_up = 1'b1;
    repeat (3) begin @(negedge clk); step(); end
    chk("lnk_grant_id", 64'(grant_id), 64'd1);
    chk("lnk_in_access", 64'(m_penable), 64'd1);
    link_up = 1'b0;
    run(20);
    chk("lnk_timeout_err", 64'(timeout_err), 64'd0);
    link_up = 1'b1;

    // Reset in the middle of an access, then port 0 must win first.
    queue_job(1, 1'b1, 32'h4000_0000, 32'h1111_2222, 4'hf, 32'h0, 1'b0);
    load(1);
    repeat (3) begin @(negedge clk); step(); end
    chk("rstm_in_access", 64'(m_penable), 64'd1);
    rst = 1'b1; req_psel = '0; req_penable = '0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    rst = 1'b0; dead = 1'b0; m_psel_prev = 1'b0; m_pready = 1'b0; wcnt = 0;
    queue_job(0, 1'b1, 32'h5000_0000, 32'h0bad_f00d, 4'h3, 32'h0, 1'b0);
    queue_job(3, 1'b1, 32'h5000_0030, 32'h7777_8888, 4'hc, 32'h0, 1'b0);
    run(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
